// File: rtl/fwd_pkg.sv
// Shared types and helpers for the forwarding / load-use hazard scoreboard.
package fwd_pkg;

   // Tags store addresses zero-extended to this width; ADDR_W must not exceed it.
   localparam int FWD_TAG_ADDR_W = 8;
   localparam int FWD_SEL_RF     = 0;

   typedef struct packed {
      logic                      valid;
      logic                      wr_en;
      logic                      is_load;
      logic [FWD_TAG_ADDR_W-1:0] addr;
   } fwd_tag_t;

   function automatic int fwd_clog2(input int value);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) r = i + 1;
      end
      return r;
   endfunction

   function automatic int fwd_sel_w(input int depth);
      return (depth < 1) ? 1 : fwd_clog2(depth + 1);
   endfunction

endpackage

// File: rtl/fwd_src_prio.sv
// Youngest-match finder for one source operand against the in-flight tag slots.
module fwd_src_prio
   import fwd_pkg::*;
#(
   parameter int ADDR_W = 5,
   parameter int DEPTH  = 2,
   parameter int IDX_W  = fwd_sel_w(DEPTH)
) (
   input  logic [ADDR_W-1:0]   i_src_addr,
   input  fwd_tag_t [DEPTH-1:0] i_slots,
   output logic                o_hit,
   output logic [IDX_W-1:0]    o_idx,
   output logic                o_is_load
);

   logic [FWD_TAG_ADDR_W-1:0] w_src;
   logic [DEPTH-1:0]          w_match;

   assign w_src = FWD_TAG_ADDR_W'(i_src_addr);

   always_comb begin
      for (int j = 0; j < DEPTH; j++) begin
         w_match[j] = i_slots[j].valid && i_slots[j].wr_en &&
                      (i_slots[j].addr != '0) && (i_slots[j].addr == w_src);
      end
   end

   // Scan oldest to youngest so the lowest matching slot index wins.
   always_comb begin
      o_hit     = 1'b0;
      o_idx     = '0;
      o_is_load = 1'b0;
      for (int j = DEPTH - 1; j >= 0; j--) begin
         if (w_match[j]) begin
            o_hit     = 1'b1;
            o_idx     = IDX_W'(j);
            o_is_load = i_slots[j].is_load;
         end
      end
   end

endmodule

// File: rtl/fwd_hazard_scoreboard.sv
// Forwarding-select and load-use stall unit for the 5-stage pipeline.
// Optional stall counter enabled by defining FWD_STALL_CNT_EN.
module fwd_hazard_scoreboard
   import fwd_pkg::*;
#(
   parameter  int ADDR_W     = 5,
   parameter  int NUM_SRC    = 2,
   parameter  int DEPTH      = 2,
   parameter  int LOAD_STAGE = 2,
   localparam int SEL_W      = fwd_sel_w(DEPTH)
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic                      hold_i,
   input  logic                      flush_i,
   input  logic                      id_valid_i,
   input  logic [NUM_SRC*ADDR_W-1:0] id_src_addr_i,
   input  logic                      id_wr_en_i,
   input  logic [ADDR_W-1:0]         id_wr_addr_i,
   input  logic                      id_is_load_i,
   output logic                      stall_o,
   output logic [NUM_SRC*SEL_W-1:0]  fwd_sel_o,
   output logic [31:0]               stall_cnt_o
);

   // Only slots 0..DEPTH-1 are ever matched against; the oldest stage's tag
   // would be dropped on the next advance anyway, so it is not stored.
   fwd_tag_t [DEPTH-1:0]       r_slot;
   logic [NUM_SRC*SEL_W-1:0]   r_fwd_sel;

   logic [NUM_SRC-1:0]         w_hit;
   logic [NUM_SRC-1:0]         w_hit_load;
   logic [NUM_SRC-1:0]         w_op_stall;
   logic [SEL_W-1:0]           w_idx [NUM_SRC];
   logic [NUM_SRC*SEL_W-1:0]   w_sel_next;
   logic                       w_issue;
   fwd_tag_t                   w_id_tag;

   for (genvar n = 0; n < NUM_SRC; n++) begin : g_src
      fwd_src_prio #(
         .ADDR_W (ADDR_W),
         .DEPTH  (DEPTH),
         .IDX_W  (SEL_W)
      ) u_prio (
         .i_src_addr (id_src_addr_i[n*ADDR_W +: ADDR_W]),
         .i_slots    (r_slot),
         .o_hit      (w_hit[n]),
         .o_idx      (w_idx[n]),
         .o_is_load  (w_hit_load[n])
      );

      // Slot j reaches forward stage j+1 when this instruction reaches EX.
      assign w_op_stall[n] = w_hit[n] && w_hit_load[n] &&
                             ((32'(w_idx[n]) + 32'd1) < 32'(LOAD_STAGE));

      assign w_sel_next[n*SEL_W +: SEL_W] =
         w_hit[n] ? (w_idx[n] + SEL_W'(1)) : SEL_W'(FWD_SEL_RF);
   end

   assign stall_o = id_valid_i && (|w_op_stall);
   assign w_issue = id_valid_i && !stall_o && !flush_i;

   always_comb begin
      w_id_tag         = '0;
      w_id_tag.valid   = 1'b1;
      w_id_tag.wr_en   = id_wr_en_i;
      w_id_tag.is_load = id_is_load_i;
      w_id_tag.addr    = FWD_TAG_ADDR_W'(id_wr_addr_i);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_slot    <= '0;
         r_fwd_sel <= '0;
      end else if (!hold_i) begin
         for (int k = DEPTH - 1; k >= 1; k--) begin
            r_slot[k] <= r_slot[k-1];
         end
         if (w_issue) begin
            r_slot[0] <= w_id_tag;
            r_fwd_sel <= w_sel_next;
         end else begin
            r_slot[0] <= '0;
            r_fwd_sel <= '0;
         end
      end
   end

   assign fwd_sel_o = r_fwd_sel;

`ifdef FWD_STALL_CNT_EN
   logic [31:0] r_stall_cnt;

   function automatic logic [31:0] sat_inc32(input logic [31:0] value);
      return (value == 32'hFFFF_FFFF) ? value : value + 32'd1;
   endfunction

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_stall_cnt <= 32'd0;
      end else if (!hold_i && stall_o) begin
         r_stall_cnt <= sat_inc32(r_stall_cnt);
      end
   end

   assign stall_cnt_o = r_stall_cnt;
`else
   assign stall_cnt_o = 32'd0;
`endif

endmodule

// File: tb/tb_fwd_hazard_scoreboard.sv
// Directed bench: default-parameter scoreboard plus a DEPTH=3 / LOAD_STAGE=3 instance.
module tb_fwd_hazard_scoreboard;

`ifdef FWD_STALL_CNT_EN
   localparam bit CNT_ON = 1'b1;
`else
   localparam bit CNT_ON = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst, hold, flush, id_valid, id_wr_en, id_is_load;
   logic [9:0]  id_src_addr;
   logic [4:0]  id_wr_addr;
   logic        stall, stall3;
   logic [3:0]  fwd_sel, fwd_sel3;
   logic [31:0] cnt, cnt3;
   logic [31:0] exp_cnt;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   fwd_hazard_scoreboard u_dut (
      .clk_i(clk), .rst_i(rst), .hold_i(hold), .flush_i(flush),
      .id_valid_i(id_valid), .id_src_addr_i(id_src_addr), .id_wr_en_i(id_wr_en),
      .id_wr_addr_i(id_wr_addr), .id_is_load_i(id_is_load),
      .stall_o(stall), .fwd_sel_o(fwd_sel), .stall_cnt_o(cnt)
   );

   fwd_hazard_scoreboard #(.DEPTH(3), .LOAD_STAGE(3)) u_dut3 (
      .clk_i(clk), .rst_i(rst), .hold_i(hold), .flush_i(flush),
      .id_valid_i(id_valid), .id_src_addr_i(id_src_addr), .id_wr_en_i(id_wr_en),
      .id_wr_addr_i(id_wr_addr), .id_is_load_i(id_is_load),
      .stall_o(stall3), .fwd_sel_o(fwd_sel3), .stall_cnt_o(cnt3)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] wd,
                        input logic we, input logic ld);
      id_valid    = 1'b1;
      id_src_addr = {rt, rs};
      id_wr_addr  = wd;
      id_wr_en    = we;
      id_is_load  = ld;
      #1;
   endtask

   task automatic idle();
      id_valid    = 1'b0;
      id_src_addr = '0;
      id_wr_addr  = '0;
      id_wr_en    = 1'b0;
      id_is_load  = 1'b0;
      #1;
   endtask

   task automatic drain();
      idle();
      repeat (4) tick();
   endtask

   task automatic test_reset();
      rst = 1'b1; hold = 1'b0; flush = 1'b0;
      idle();
      repeat (2) tick();
      rst = 1'b0;
      exp_cnt = 0;
      n_checks++;
      if (fwd_sel !== 4'b0000) begin n_fail++; $display("FAIL reset_sel got %b want 0000", fwd_sel); end
      n_checks++;
      if (stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall got %b want 0", stall); end
      n_checks++;
      if (cnt !== 32'd0) begin n_fail++; $display("FAIL reset_cnt got %0d want 0", cnt); end
   endtask

   task automatic test_alu_chain();
      drive(5'd2, 5'd1, 5'd3, 1'b1, 1'b0);
      tick();
      drive(5'd3, 5'd4, 5'd6, 1'b1, 1'b0);
      n_checks++;
      if (stall !== 1'b0) begin n_fail++; $display("FAIL alu_stall got %b want 0", stall); end
      tick();
      n_checks++;
      if (fwd_sel !== 4'b0001) begin n_fail++; $display("FAIL alu_sel got %b want 0001", fwd_sel); end
      idle();
      tick();
      n_checks++;
      if (fwd_sel !== 4'b0000) begin n_fail++; $display("FAIL alu_bubble_sel got %b want 0000", fwd_sel); end
   endtask

   task automatic test_distance2();
      drain();
      drive(5'd0, 5'd0, 5'd5, 1'b1, 1'b0);
      tick();
      drive(5'd1, 5'd2, 5'd8, 1'b1, 1'b0);
      tick();
      drive(5'd1, 5'd5, 5'd9, 1'b1, 1'b0);
      tick();
      n_checks++;
      if (fwd_sel !== 4'b1000) begin n_fail++; $display("FAIL dist2_sel got %b want 1000", fwd_sel); end
   endtask

   task automatic test_load_use();
      drain();
      drive(5'd1, 5'd2, 5'd4, 1'b1, 1'b1);
      tick();
      idle();
      n_checks++;
      if (stall !== 1'b0) begin n_fail++; $display("FAIL lu_invalid_stall got %b want 0", stall); end
      drive(5'd4, 5'd0, 5'd6, 1'b1, 1'b0);
      n_checks++;
      if (stall !== 1'b1) begin n_fail++; $display("FAIL lu_stall got %b want 1", stall); end
      tick();
      exp_cnt = exp_cnt + 1;
      n_checks++;
      if (fwd_sel !== 4'b0000) begin n_fail++; $display("FAIL lu_bubble_sel got %b want 0000", fwd_sel); end
      n_checks++;
      if (stall !== 1'b0) begin n_fail++; $display("FAIL lu_stall_release got %b want 0", stall); end
      tick();
      n_checks++;
      if (fwd_sel !== 4'b0010) begin n_fail++; $display("FAIL lu_sel got %b want 0010", fwd_sel); end
      n_checks++;
      if (cnt !== (CNT_ON ? exp_cnt : 32'd0)) begin
         n_fail++; $display("FAIL lu_cnt got %0d want %0d", cnt, CNT_ON ? exp_cnt : 32'd0);
      end
   endtask

   task automatic test_priority();
      drain();
      drive(5'd1, 5'd2, 5'd7, 1'b1, 1'b0);
      tick();
      drive(5'd1, 5'd2, 5'd7, 1'b1, 1'b0);
      tick();
      drive(5'd7, 5'd7, 5'd10, 1'b1, 1'b0);
      tick();
      n_checks++;
      if (fwd_sel !== 4'b0101) begin n_fail++; $display("FAIL prio_sel got %b want 0101", fwd_sel); end
      drive(5'd1, 5'd2, 5'd0, 1'b1, 1'b0);
      tick();
      drive(5'd0, 5'd10, 5'd13, 1'b1, 1'b0);
      tick();
      n_checks++;
      if (fwd_sel !== 4'b1000) begin n_fail++; $display("FAIL zero_sel got %b want 1000", fwd_sel); end
      drain();
      drive(5'd1, 5'd2, 5'd0, 1'b1, 1'b1);
      tick();
      drive(5'd0, 5'd0, 5'd14, 1'b1, 1'b0);
      n_checks++;
      if (stall !== 1'b0) begin n_fail++; $display("FAIL zero_load_stall got %b want 0", stall); end
   endtask

   task automatic test_hold();
      drain();
      drive(5'd1, 5'd2, 5'd3, 1'b1, 1'b0);
      tick();
      drive(5'd3, 5'd0, 5'd11, 1'b1, 1'b0);
      tick();
      hold = 1'b1;
      drive(5'd11, 5'd3, 5'd15, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) begin
         tick();
         n_checks++;
         if (fwd_sel !== 4'b0001) begin n_fail++; $display("FAIL hold_sel[%0d] got %b want 0001", i, fwd_sel); end
      end
      hold = 1'b0;
      tick();
      n_checks++;
      if (fwd_sel !== 4'b1001) begin n_fail++; $display("FAIL hold_release_sel got %b want 1001", fwd_sel); end
      drain();
      drive(5'd1, 5'd2, 5'd4, 1'b1, 1'b1);
      tick();
      hold = 1'b1;
      drive(5'd4, 5'd0, 5'd6, 1'b1, 1'b0);
      n_checks++;
      if (stall !== 1'b1) begin n_fail++; $display("FAIL hold_stall got %b want 1", stall); end
      repeat (2) tick();
      n_checks++;
      if (cnt !== (CNT_ON ? exp_cnt : 32'd0)) begin
         n_fail++; $display("FAIL hold_cnt got %0d want %0d", cnt, CNT_ON ? exp_cnt : 32'd0);
      end
      hold = 1'b0;
      tick();
      exp_cnt = exp_cnt + 1;
      tick();
      n_checks++;
      if (fwd_sel !== 4'b0010) begin n_fail++; $display("FAIL hold_lu_sel got %b want 0010", fwd_sel); end
      n_checks++;
      if (cnt !== (CNT_ON ? exp_cnt : 32'd0)) begin
         n_fail++; $display("FAIL hold_lu_cnt got %0d want %0d", cnt, CNT_ON ? exp_cnt : 32'd0);
      end
   endtask

   task automatic test_flush();
      drain();
      drive(5'd1, 5'd2, 5'd3, 1'b1, 1'b0);
      tick();
      flush = 1'b1;
      drive(5'd3, 5'd0, 5'd12, 1'b1, 1'b0);
      tick();
      flush = 1'b0;
      n_checks++;
      if (fwd_sel !== 4'b0000) begin n_fail++; $display("FAIL flush_sel got %b want 0000", fwd_sel); end
      drive(5'd3, 5'd12, 5'd13, 1'b1, 1'b0);
      tick();
      n_checks++;
      if (fwd_sel !== 4'b0010) begin n_fail++; $display("FAIL flush_slot0_sel got %b want 0010", fwd_sel); end
   endtask

   task automatic test_reset_mid();
      drain();
      drive(5'd1, 5'd2, 5'd3, 1'b1, 1'b0);
      tick();
      drive(5'd1, 5'd2, 5'd4, 1'b1, 1'b1);
      tick();
      rst = 1'b1;
      drive(5'd3, 5'd4, 5'd5, 1'b1, 1'b0);
      tick();
      rst = 1'b0;
      exp_cnt = 0;
      #1;
      n_checks++;
      if (fwd_sel !== 4'b0000) begin n_fail++; $display("FAIL rstmid_sel got %b want 0000", fwd_sel); end
      n_checks++;
      if (stall !== 1'b0) begin n_fail++; $display("FAIL rstmid_stall got %b want 0", stall); end
      tick();
      n_checks++;
      if (fwd_sel !== 4'b0000) begin n_fail++; $display("FAIL rstmid_stale_sel got %b want 0000", fwd_sel); end
      n_checks++;
      if (cnt !== 32'd0) begin n_fail++; $display("FAIL rstmid_cnt got %0d want 0", cnt); end
   endtask

   task automatic test_deep_load();
      rst = 1'b1;
      idle();
      tick();
      rst = 1'b0;
      drive(5'd1, 5'd2, 5'd9, 1'b1, 1'b1);
      tick();
      drive(5'd9, 5'd0, 5'd10, 1'b1, 1'b0);
      n_checks++;
      if (stall3 !== 1'b1) begin n_fail++; $display("FAIL deep_stall0 got %b want 1", stall3); end
      tick();
      n_checks++;
      if (stall3 !== 1'b1) begin n_fail++; $display("FAIL deep_stall1 got %b want 1", stall3); end
      n_checks++;
      if (fwd_sel3 !== 4'b0000) begin n_fail++; $display("FAIL deep_bubble_sel got %b want 0000", fwd_sel3); end
      tick();
      n_checks++;
      if (stall3 !== 1'b0) begin n_fail++; $display("FAIL deep_stall2 got %b want 0", stall3); end
      tick();
      n_checks++;
      if (fwd_sel3 !== 4'b0011) begin n_fail++; $display("FAIL deep_sel got %b want 0011", fwd_sel3); end
      n_checks++;
      if (cnt3 !== (CNT_ON ? 32'd2 : 32'd0)) begin
         n_fail++; $display("FAIL deep_cnt got %0d want %0d", cnt3, CNT_ON ? 32'd2 : 32'd0);
      end
      idle();
   endtask

   initial begin
      test_reset();
      test_alu_chain();
      test_distance2();
      test_load_use();
      test_priority();
      test_hold();
      test_flush();
      test_reset_mid();
      test_deep_load();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
